// File: rtl/des_pkg.sv
// des_pkg: shared FSM state encoding, round-counter width and DES shift schedule.
`default_nettype none

package des_pkg;

   localparam int ROUND_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Encrypt left-shift schedule, entry [i] is round i (entry 15 written first).
   localparam logic [15:0][1:0] ENC_SHIFT = {
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
      2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
   };

endpackage

`default_nettype wire

// File: rtl/des_rot_sched.sv
// des_rot_sched: combinational C/D rotation amount for a given round and direction.
`default_nettype none

module des_rot_sched
   import des_pkg::*;
(
   input  logic [ROUND_W-1:0] rnd_idx,
   input  logic               decrypt,
   output logic [1:0]         rot_amt
);

   logic [ROUND_W-1:0] rev_idx;

   // Decrypt walks the encrypt schedule backwards: round n uses entry 16-n,
   // and round 0 uses no rotation since C/D already equal the round-16 state.
   always_comb begin
      rev_idx = ~rnd_idx + 4'd1;
      rot_amt = ENC_SHIFT[rnd_idx];
      if (decrypt) begin
         rot_amt = (rnd_idx == '0) ? 2'd0 : ENC_SHIFT[rev_idx];
      end
   end

endmodule

`default_nettype wire

// File: rtl/des_iter_ctrl.sv
// des_iter_ctrl: one-round-per-clock DES sequencer with valid/ready host and result ports.
// Optional abort input enabled by defining DES_ITER_CTRL_ABORT_EN.
`default_nettype none

module des_iter_ctrl
   import des_pkg::*;
#(
   parameter int ROUNDS = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_decrypt,
`ifdef DES_ITER_CTRL_ABORT_EN
   input  logic               abort,
`endif
   output logic               ld,
   output logic               rnd_en,
   output logic [ROUND_W-1:0] rnd_idx,
   output logic [1:0]         rot_amt,
   output logic               rot_left,
   output logic               last_rnd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy
);

   localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(ROUNDS - 1);

   state_t             state_q, state_d;
   logic [ROUND_W-1:0] cnt_q, cnt_d;
   logic               dec_q, dec_d;
   logic [1:0]         sched_amt;

   des_rot_sched u_rot_sched (
      .rnd_idx (cnt_q),
      .decrypt (dec_q),
      .rot_amt (sched_amt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;

      in_ready  = (state_q == ST_IDLE) && !rst;
      ld        = in_valid && in_ready;
      rnd_en    = 1'b0;
      rnd_idx   = '0;
      rot_amt   = 2'd0;
      rot_left  = 1'b0;
      last_rnd  = 1'b0;
      out_valid = 1'b0;
      busy      = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (ld) begin
               dec_d   = in_decrypt;
               cnt_d   = '0;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            rnd_en   = !rst;
            rnd_idx  = cnt_q;
            rot_amt  = rst ? 2'd0 : sched_amt;
            rot_left = !dec_q;
            last_rnd = (cnt_q == LAST_IDX) && !rst;
            if (cnt_q == LAST_IDX) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DONE: begin
            out_valid = !rst;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

`ifdef DES_ITER_CTRL_ABORT_EN
      // Abort only matters once a block is in flight; an accept in IDLE wins.
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_des_iter_ctrl.sv
// tb_des_iter_ctrl: directed self-checking bench for the DES round sequencer.
`default_nettype none

module tb_des_iter_ctrl;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_decrypt;
   logic       ld;
   logic       rnd_en;
   logic [3:0] rnd_idx;
   logic [1:0] rot_amt;
   logic       rot_left;
   logic       last_rnd;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
`ifdef DES_ITER_CTRL_ABORT_EN
   logic       abort;
`endif

   int total = 0;
   int bad   = 0;

   int enc_tab [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   int dec_tab [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   des_iter_ctrl #(.ROUNDS(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_decrypt (in_decrypt),
`ifdef DES_ITER_CTRL_ABORT_EN
      .abort      (abort),
`endif
      .ld         (ld),
      .rnd_en     (rnd_en),
      .rnd_idx    (rnd_idx),
      .rot_amt    (rot_amt),
      .rot_left   (rot_left),
      .last_rnd   (last_rnd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_decrypt = 1'b0; out_ready = 1'b0;
`ifdef DES_ITER_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({in_ready, ld, rnd_en, rnd_idx, rot_amt, rot_left, last_rnd, out_valid, busy} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs got in_ready=%b ld=%b rnd_en=%b idx=%0d amt=%0d left=%b last=%b ov=%b busy=%b want all 0",
                  in_ready, ld, rnd_en, rnd_idx, rot_amt, rot_left, last_rnd, out_valid, busy);
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got in_ready=%b busy=%b want 1 0", in_ready, busy);
      end
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_out_ready_ignored got in_ready=%b busy=%b ov=%b want 1 0 0", in_ready, busy, out_valid);
      end
   endtask

   task automatic test_block(input logic dec);
      int exp_amt;
      @(negedge clk);
      in_valid = 1'b1; in_decrypt = dec; out_ready = 1'b0;
      #1;
      total++;
      if (ld !== 1'b1 || in_ready !== 1'b1 || rnd_en !== 1'b0) begin
         bad++;
         $display("FAIL accept_dec%0d got ld=%b in_ready=%b rnd_en=%b want 1 1 0", dec, ld, in_ready, rnd_en);
      end
      for (int r = 0; r < 16; r++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_decrypt = ~dec;
         #1;
         exp_amt = dec ? dec_tab[r] : enc_tab[r];
         total++;
         if (rnd_en !== 1'b1 || rnd_idx !== 4'(r) || rot_amt !== 2'(exp_amt) || rot_left !== !dec
             || last_rnd !== (r == 15) || ld !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL round_dec%0d_r%0d got en=%b idx=%0d amt=%0d left=%b last=%b ld=%b ov=%b rdy=%b want 1 %0d %0d %b %b 0 0 0",
                     dec, r, rnd_en, rnd_idx, rot_amt, rot_left, last_rnd, ld, out_valid, in_ready,
                     r, exp_amt, !dec, (r == 15));
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b1 || rnd_en !== 1'b0 || rot_amt !== 2'd0 || last_rnd !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL done_dec%0d got ov=%b en=%b amt=%0d last=%b rdy=%b busy=%b want 1 0 0 0 0 1",
                  dec, out_valid, rnd_en, rot_amt, last_rnd, in_ready, busy);
      end
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL back_idle_dec%0d got ov=%b rdy=%b busy=%b want 0 1 0", dec, out_valid, in_ready, busy);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      in_valid = 1'b1; in_decrypt = 1'b0; out_ready = 1'b0;
      #1;
      total++;
      if (ld !== 1'b1) begin
         bad++;
         $display("FAIL bp_accept got ld=%b want 1", ld);
      end
      for (int r = 0; r < 16; r++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1; out_ready = 1'b0;
         #1;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || ld !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold_%0d got ov=%b rdy=%b ld=%b want 1 0 0", k, out_valid, in_ready, ld);
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_release got ov=%b want 1", out_valid);
      end
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_after got rdy=%b ov=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_rst_mid_round();
      @(negedge clk);
      in_valid = 1'b1; in_decrypt = 1'b1; out_ready = 1'b0;
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      #1;
      total++;
      if (rnd_idx !== 4'd7 || rnd_en !== 1'b1) begin
         bad++;
         $display("FAIL rst_pre got idx=%0d en=%b want 7 1", rnd_idx, rnd_en);
      end
      rst = 1'b1; in_valid = 1'b1;
      #1;
      total++;
      if (ld !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_vs_accept got ld=%b rdy=%b want 0 0", ld, in_ready);
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1; in_decrypt = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || rnd_idx !== 4'd0 || out_valid !== 1'b0 || rnd_en !== 1'b0 || ld !== 1'b1) begin
         bad++;
         $display("FAIL rst_after got busy=%b idx=%0d ov=%b en=%b ld=%b want 0 0 0 0 1", busy, rnd_idx, out_valid, rnd_en, ld);
      end
      for (int r = 0; r < 16; r++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         total++;
         if (rnd_en !== 1'b1 || rnd_idx !== 4'(r) || out_valid !== 1'b0 || rot_left !== 1'b1) begin
            bad++;
            $display("FAIL rst_newblk_r%0d got en=%b idx=%0d ov=%b left=%b want 1 %0d 0 1", r, rnd_en, rnd_idx, out_valid, rot_left, r);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_newblk_done got ov=%b want 1", out_valid);
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

`ifdef DES_ITER_CTRL_ABORT_EN
   task automatic test_abort();
      logic seen;
      @(negedge clk);
      in_valid = 1'b1; in_decrypt = 1'b0; out_ready = 1'b1; abort = 1'b0;
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      abort = 1'b1;
      #1;
      total++;
      if (rnd_idx !== 4'd3 || rnd_en !== 1'b1) begin
         bad++;
         $display("FAIL abort_cycle got idx=%0d en=%b want 3 1", rnd_idx, rnd_en);
      end
      @(negedge clk);
      abort = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL abort_after got busy=%b rdy=%b ov=%b want 0 1 0", busy, in_ready, out_valid);
      end
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL abort_no_result got ov_seen=%b want 0", seen);
      end
      @(negedge clk);
      abort = 1'b1; in_valid = 1'b1;
      #1;
      total++;
      if (ld !== 1'b1) begin
         bad++;
         $display("FAIL abort_idle_accept got ld=%b want 1", ld);
      end
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      #1;
      total++;
      if (rnd_en !== 1'b1 || rnd_idx !== 4'd0) begin
         bad++;
         $display("FAIL abort_idle_proceed got en=%b idx=%0d want 1 0", rnd_en, rnd_idx);
      end
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b1) begin
         bad++;
         $display("FAIL abort_idle_result got ov_seen=%b want 1", seen);
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_block(1'b0);
      test_block(1'b1);
      test_backpressure();
      test_rst_mid_round();
`ifdef DES_ITER_CTRL_ABORT_EN
      test_abort();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
